// File: rtl/unsaved_multi_timer_pkg.sv
// Shared register map and bit positions for the multi-channel interval timer.
package unsaved_multi_timer_pkg;
  localparam logic [2:0] REG_STATUS   = 3'd0;
  localparam logic [2:0] REG_CONTROL  = 3'd1;
  localparam logic [2:0] REG_PERIOD   = 3'd2;
  localparam logic [2:0] REG_COMPARE  = 3'd3;
  localparam logic [2:0] REG_SNAP     = 3'd4;
  localparam logic [2:0] REG_PRESCALE = 3'd5;

  localparam int ST_TO     = 0;
  localparam int ST_RUN    = 1;
  localparam int CT_ITO    = 0;
  localparam int CT_CONT   = 1;
  localparam int CT_START  = 2;
  localparam int CT_STOP   = 3;
  localparam int CT_PWM_EN = 4;
endpackage

// File: rtl/unsaved_timer_channel.sv
// One timer channel: prescaler, down-counter, control/status, snapshot and PWM.
module unsaved_timer_channel
  import unsaved_multi_timer_pkg::*;
#(
  parameter int          CNT_W        = 32,
  parameter int          PRE_W        = 8,
  parameter logic [31:0] RESET_PERIOD = 32'h005F_5E0F
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_we,
  input  logic [2:0]  i_reg,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_irq,
  output logic        o_pwm
);
  localparam logic [CNT_W-1:0] RST_CNT = RESET_PERIOD[CNT_W-1:0];

  logic [CNT_W-1:0] r_cnt, r_period, r_cmp, r_snap;
  logic [PRE_W-1:0] r_pre, r_pcnt;
  logic             r_ito, r_cont, r_pwm_en, r_run, r_to, r_reload, r_zero_d, r_pwm;

  logic w_wr_status, w_wr_ctrl, w_wr_period, w_wr_cmp, w_wr_snap, w_wr_pre;
  logic w_start, w_stop, w_tick, w_step, w_oneshot_end, w_zero;
  logic [CNT_W-1:0] w_adv;

  assign w_wr_status = i_we && (i_reg == REG_STATUS);
  assign w_wr_ctrl   = i_we && (i_reg == REG_CONTROL);
  assign w_wr_period = i_we && (i_reg == REG_PERIOD);
  assign w_wr_cmp    = i_we && (i_reg == REG_COMPARE);
  assign w_wr_snap   = i_we && (i_reg == REG_SNAP);
  assign w_wr_pre    = i_we && (i_reg == REG_PRESCALE);
  assign w_start     = w_wr_ctrl && i_wdata[CT_START];
  assign w_stop      = w_wr_ctrl && i_wdata[CT_STOP];

  assign w_tick = (r_pcnt == '0);
  assign w_zero = (r_cnt == '0);
  assign w_adv  = w_zero ? r_period : r_cnt - 1'b1;
  assign w_step = w_tick && r_run && !r_reload;
  // One-shot stops on the same edge the counter lands on 0, so a later START
  // from 0 reloads instead of immediately stopping again.
  assign w_oneshot_end = w_step && !r_cont && (w_adv == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= RST_CNT;
      r_period <= RST_CNT;
      r_cmp    <= '0;
      r_snap   <= '0;
      r_pre    <= '0;
      r_pcnt   <= '0;
      r_ito    <= 1'b0;
      r_cont   <= 1'b0;
      r_pwm_en <= 1'b0;
      r_run    <= 1'b0;
      r_to     <= 1'b0;
      r_reload <= 1'b0;
      r_zero_d <= (RST_CNT == '0);
      r_pwm    <= 1'b0;
    end else begin
      if (w_wr_period) r_period <= i_wdata[CNT_W-1:0];
      if (w_wr_cmp)    r_cmp    <= i_wdata[CNT_W-1:0];
      if (w_wr_pre)    r_pre    <= i_wdata[PRE_W-1:0];
      if (w_wr_snap)   r_snap   <= r_cnt;
      if (w_wr_ctrl) begin
        r_ito    <= i_wdata[CT_ITO];
        r_cont   <= i_wdata[CT_CONT];
        r_pwm_en <= i_wdata[CT_PWM_EN];
      end
      r_reload <= w_wr_period;

      if (r_reload)    r_cnt <= r_period;
      else if (w_step) r_cnt <= w_adv;

      if (w_start || w_wr_period) r_pcnt <= '0;
      else if (w_tick)            r_pcnt <= r_pre;
      else                        r_pcnt <= r_pcnt - 1'b1;

      if (w_start)                                   r_run <= 1'b1;
      else if (w_stop || r_reload || w_oneshot_end) r_run <= 1'b0;

      r_zero_d <= w_zero;
      if (w_zero && !r_zero_d) r_to <= 1'b1;
      else if (w_wr_status)    r_to <= 1'b0;

      r_pwm <= r_pwm_en && r_run && (r_cnt < r_cmp);
    end
  end

  always_comb begin
    o_rdata = '0;
    case (i_reg)
      REG_STATUS: begin
        o_rdata[ST_TO]  = r_to;
        o_rdata[ST_RUN] = r_run;
      end
      REG_CONTROL: begin
        o_rdata[CT_ITO]    = r_ito;
        o_rdata[CT_CONT]   = r_cont;
        o_rdata[CT_PWM_EN] = r_pwm_en;
      end
      REG_PERIOD:   o_rdata[CNT_W-1:0] = r_period;
      REG_COMPARE:  o_rdata[CNT_W-1:0] = r_cmp;
      REG_SNAP:     o_rdata[CNT_W-1:0] = r_snap;
      REG_PRESCALE: o_rdata[PRE_W-1:0] = r_pre;
      default:      o_rdata = '0;
    endcase
  end

  assign o_irq = r_to && r_ito;
  assign o_pwm = r_pwm;
endmodule

// File: rtl/unsaved_multi_timer.sv
// NUM_CH-channel interval timer behind one Avalon-MM slave: decode, read mux, irq.
module unsaved_multi_timer
  import unsaved_multi_timer_pkg::*;
#(
  parameter int          NUM_CH       = 4,
  parameter int          CNT_W        = 32,
  parameter int          PRE_W        = 8,
  parameter logic [31:0] RESET_PERIOD = 32'h005F_5E0F
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [$clog2(NUM_CH)+2:0]   address,
  input  logic                        chipselect,
  input  logic                        write_n,
  input  logic [31:0]                 writedata,
  output logic [31:0]                 readdata,
  output logic                        irq,
  output logic [NUM_CH-1:0]           pwm_out
);
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [CHW-1:0]               w_ch;
  logic                         w_ch_ok, w_we;
  logic [NUM_CH-1:0][31:0]      w_rdata;
  logic [NUM_CH-1:0]            w_irq;
  logic [31:0]                  r_rdata;
  logic                         r_irq;

  if (NUM_CH > 1) begin : g_multi
    assign w_ch = address[$clog2(NUM_CH)+2:3];
  end else begin : g_single
    assign w_ch = '0;
  end

  assign w_ch_ok = (32'(w_ch) < NUM_CH);
  assign w_we    = chipselect && !write_n && w_ch_ok;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    unsaved_timer_channel #(
      .CNT_W        (CNT_W),
      .PRE_W        (PRE_W),
      .RESET_PERIOD (RESET_PERIOD)
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .i_we    (w_we && (w_ch == CHW'(gi))),
      .i_reg   (address[2:0]),
      .i_wdata (writedata),
      .o_rdata (w_rdata[gi]),
      .o_irq   (w_irq[gi]),
      .o_pwm   (pwm_out[gi])
    );
  end

  // Read data is registered every clock so the bus sees a fixed one-cycle latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_rdata <= w_ch_ok ? w_rdata[w_ch] : '0;
      r_irq   <= |w_irq;
    end
  end

  assign readdata = r_rdata;
  assign irq      = r_irq;
endmodule

// File: tb/tb_unsaved_multi_timer.sv
// Directed bench for unsaved_multi_timer: reset, timeout/irq, one-shot, PWM, snapshot.
module tb_unsaved_multi_timer;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  logic [3:0]  pwm_out;

  int n_cmp = 0;
  int n_err = 0;

  unsaved_multi_timer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .pwm_out    (pwm_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input int ch, input int rg, input logic [31:0] d);
    address    = 5'((ch << 3) | rg);
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input int ch, input int rg, output logic [31:0] v);
    address    = 5'((ch << 3) | rg);
    chipselect = 1'b1;
    write_n    = 1'b1;
    @(posedge clk); #1;
    v          = readdata;
    chipselect = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    logic        exp_pwm;
    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    cyc(3);
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_pwm", {28'h0, pwm_out}, 32'h0);
    @(posedge clk); #2 reset_n = 1'b1;
    cyc(1);
    rd(0, 2, v); chk("rst_period_ch0", v, 32'h005F5E0F);
    rd(0, 0, v); chk("rst_status_ch0", v, 32'h0);
    rd(3, 1, v); chk("rst_control_ch3", v, 32'h0);

    // ch1 continuous, period 4, no prescale: TO every 5 clocks
    wr(1, 2, 32'd4);
    wr(1, 5, 32'd0);
    wr(1, 1, 32'h7);
    cyc(4);
    rd(1, 0, v); chk("ch1_status_e5_pre", v, 32'h2);
    chk("ch1_irq_before", {31'h0, irq}, 32'h0);
    rd(1, 0, v); chk("ch1_status_to", v, 32'h3);
    chk("ch1_irq_after", {31'h0, irq}, 32'h1);
    wr(1, 0, 32'h0);
    cyc(1);
    chk("ch1_irq_cleared", {31'h0, irq}, 32'h0);
    rd(1, 0, v); chk("ch1_status_e9", v, 32'h2);
    rd(1, 0, v); chk("ch1_status_e10", v, 32'h2);
    rd(1, 0, v); chk("ch1_status_e11", v, 32'h3);
    wr(1, 0, 32'h0);
    cyc(2);
    wr(1, 0, 32'h0);
    rd(1, 0, v); chk("ch1_to_set_wins", v, 32'h3);
    wr(1, 1, 32'h0B);
    rd(1, 0, v); chk("ch1_stop_run", v & 32'h2, 32'h0);
    wr(1, 1, 32'h0E);
    rd(1, 0, v); chk("ch1_start_stop_run", v & 32'h2, 32'h2);
    rd(1, 1, v); chk("ch1_control_rb", v, 32'h2);
    wr(1, 1, 32'h08);

    // ch2 one-shot, period 3, prescale 2
    wr(2, 2, 32'd3);
    wr(2, 5, 32'd2);
    wr(2, 1, 32'h5);
    wr(2, 4, 32'h0); rd(2, 4, v); chk("ch2_snap3", v, 32'd3);
    wr(2, 4, 32'h0); rd(2, 4, v); chk("ch2_snap2", v, 32'd2);
    wr(2, 4, 32'h0); rd(2, 4, v); chk("ch2_snap1", v, 32'd1);
    rd(2, 0, v); chk("ch2_running", v, 32'h2);
    rd(2, 0, v); chk("ch2_stopped", v, 32'h0);
    rd(2, 0, v); chk("ch2_to", v, 32'h1);
    chk("ch2_irq", {31'h0, irq}, 32'h1);
    cyc(5);
    wr(2, 4, 32'h0); rd(2, 4, v); chk("ch2_hold0", v, 32'd0);
    rd(2, 0, v); chk("ch2_status_hold", v, 32'h1);

    // ch0 PWM: period 9, compare 3 -> 3 high of every 10
    wr(0, 2, 32'd9);
    wr(0, 3, 32'd3);
    wr(0, 1, 32'h16);
    for (int k = 1; k <= 20; k++) begin
      cyc(1);
      exp_pwm = (k >= 8) && (((k - 8) % 10) < 3);
      chk($sformatf("pwm_k%0d", k), {31'h0, pwm_out[0]}, {31'h0, exp_pwm});
    end
    wr(0, 3, 32'd0);
    cyc(1);
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      chk("pwm_cmp0_low", {28'h0, pwm_out}, 32'h0);
    end
    wr(0, 3, 32'd20);
    cyc(1);
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      chk("pwm_cmp_gt_high", {28'h0, pwm_out}, 32'h1);
    end

    wr(0, 6, 32'hFFFF_FFFF);
    rd(0, 6, v); chk("reg6_reads0", v, 32'h0);
    rd(0, 2, v); chk("ch0_period9", v, 32'd9);
    chk("pre_reset_irq", {31'h0, irq}, 32'h1);

    // asynchronous reset in mid-cycle
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_readdata", readdata, 32'h0);
    chk("async_rst_irq", {31'h0, irq}, 32'h0);
    chk("async_rst_pwm", {28'h0, pwm_out}, 32'h0);
    cyc(2);
    #2 reset_n = 1'b1;
    cyc(1);
    rd(0, 2, v); chk("post_rst_period", v, 32'h005F5E0F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
